// File: rtl/micro_hash_nonce_ctrl.sv
// -----------------------------------------------------------------------------
// micro_hash_nonce_ctrl
//
// Nonce-search sequencer for the micro-hash core. Each attempt builds a
// 128-bit block {nonce_cur, payload}, restarts the core, waits for its digest,
// and compares the top two digest bytes against an 8-bit target. The search
// ends on the first hit, on range exhaustion, on abort, or on a core timeout.
//
// Parameters
//   NONCE_W   nonce width; payload width is 128-NONCE_W
//   TIMEOUT   max cycles spent in WAIT before err_timeout (80..65535)
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start, abort         search request (IDLE only) / search cancel (busy only)
//   payload              low block bits, captured on accepted start
//   nonce_start/last     inclusive nonce range, captured on accepted start
//   target               difficulty byte, captured on accepted start
//   hash_block           {nonce_cur, payload} to the core
//   hash_next            core clear/restart (high in IDLE and LOAD)
//   hash_finish          holds the core cleared while in DONE
//   hash_h, hash_valid   core digest and its one-cycle valid pulse
//   busy                 high in LOAD/WAIT/CHECK
//   done, found          one-cycle completion pulse and hit flag
//   nonce_out, hash_out  winning (or last tried) nonce and its digest
//   err_timeout          sticky core-timeout flag, cleared by start
//
// Optional feature (macro HASH_CTRL_STATS_EN)
//   Adds attempts[31:0] (CHECK count) and cycles[31:0] (busy cycle count),
//   both cleared on accepted start and saturating.
// -----------------------------------------------------------------------------
module micro_hash_nonce_ctrl #(
   parameter int NONCE_W = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [127-NONCE_W:0] payload,
   input  logic [NONCE_W-1:0]   nonce_start,
   input  logic [NONCE_W-1:0]   nonce_last,
   input  logic [7:0]           target,
   output logic [127:0]         hash_block,
   output logic                 hash_next,
   output logic                 hash_finish,
   input  logic [23:0]          hash_h,
   input  logic                 hash_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 found,
   output logic [NONCE_W-1:0]   nonce_out,
   output logic [23:0]          hash_out,
`ifdef HASH_CTRL_STATS_EN
   output logic [31:0]          attempts,
   output logic [31:0]          cycles,
`endif
   output logic                 err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_e;

   localparam logic [15:0]        TimeoutVal = 16'(TIMEOUT);
   localparam logic [NONCE_W-1:0] NonceMax   = '1;

   state_e               state_q, state_d;
   logic [127-NONCE_W:0] payload_q, payload_d;
   logic [7:0]           target_q, target_d;
   logic [NONCE_W-1:0]   nonce_cur_q, nonce_cur_d;
   logic [NONCE_W-1:0]   nonce_last_q, nonce_last_d;
   logic [15:0]          wait_cnt_q, wait_cnt_d;
   logic [23:0]          digest_q, digest_d;
   logic                 found_q, found_d;
   logic [NONCE_W-1:0]   nonce_out_q, nonce_out_d;
   logic [23:0]          hash_out_q, hash_out_d;
   logic                 err_q, err_d;
`ifdef HASH_CTRL_STATS_EN
   logic [31:0]          attempts_q, attempts_d;
   logic [31:0]          cycles_q, cycles_d;
`endif

   logic busy_st;
   logic hit;
   logic range_end;

   assign busy_st = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_CHECK);

   // Both upper digest bytes must be strictly below the target, so a
   // target of zero can never produce a hit.
   assign hit = (digest_q[23:16] < target_q) && (digest_q[15:8] < target_q);

   // Using >= rather than == also covers a range given backwards
   // (nonce_start > nonce_last): the first attempt is then the last one.
   // The all-ones test stops the counter from wrapping to zero.
   assign range_end = (nonce_cur_q >= nonce_last_q) || (nonce_cur_q == NonceMax);

   // Next-state and datapath logic. Abort takes priority over everything
   // in the busy states, including a digest arriving in the same cycle, and
   // leaves the result registers untouched.
   always_comb begin
      state_d      = state_q;
      payload_d    = payload_q;
      target_d     = target_q;
      nonce_cur_d  = nonce_cur_q;
      nonce_last_d = nonce_last_q;
      wait_cnt_d   = wait_cnt_q;
      digest_d     = digest_q;
      found_d      = found_q;
      nonce_out_d  = nonce_out_q;
      hash_out_d   = hash_out_q;
      err_d        = err_q;
`ifdef HASH_CTRL_STATS_EN
      attempts_d   = attempts_q;
      cycles_d     = cycles_q;
      if (busy_st && (cycles_q != 32'hFFFF_FFFF)) begin
         cycles_d = cycles_q + 32'd1;
      end
`endif

      if (abort && busy_st) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  payload_d    = payload;
                  target_d     = target;
                  nonce_cur_d  = nonce_start;
                  nonce_last_d = nonce_last;
                  err_d        = 1'b0;
`ifdef HASH_CTRL_STATS_EN
                  attempts_d   = '0;
                  cycles_d     = '0;
`endif
                  state_d      = S_LOAD;
               end
            end
            S_LOAD: begin
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end
            S_WAIT: begin
               if (hash_valid) begin
                  digest_d = hash_h;
                  state_d  = S_CHECK;
               end else if (wait_cnt_q == TimeoutVal) begin
                  err_d       = 1'b1;
                  found_d     = 1'b0;
                  nonce_out_d = nonce_cur_q;
                  hash_out_d  = digest_q;
                  state_d     = S_DONE;
               end else begin
                  wait_cnt_d = wait_cnt_q + 16'd1;
               end
            end
            S_CHECK: begin
`ifdef HASH_CTRL_STATS_EN
               if (attempts_q != 32'hFFFF_FFFF) begin
                  attempts_d = attempts_q + 32'd1;
               end
`endif
               if (hit || range_end) begin
                  found_d     = hit;
                  nonce_out_d = nonce_cur_q;
                  hash_out_d  = digest_q;
                  state_d     = S_DONE;
               end else begin
                  nonce_cur_d = nonce_cur_q + 1'b1;
                  state_d     = S_LOAD;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         payload_q    <= '0;
         target_q     <= '0;
         nonce_cur_q  <= '0;
         nonce_last_q <= '0;
         wait_cnt_q   <= '0;
         digest_q     <= '0;
         found_q      <= 1'b0;
         nonce_out_q  <= '0;
         hash_out_q   <= '0;
         err_q        <= 1'b0;
`ifdef HASH_CTRL_STATS_EN
         attempts_q   <= '0;
         cycles_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         payload_q    <= payload_d;
         target_q     <= target_d;
         nonce_cur_q  <= nonce_cur_d;
         nonce_last_q <= nonce_last_d;
         wait_cnt_q   <= wait_cnt_d;
         digest_q     <= digest_d;
         found_q      <= found_d;
         nonce_out_q  <= nonce_out_d;
         hash_out_q   <= hash_out_d;
         err_q        <= err_d;
`ifdef HASH_CTRL_STATS_EN
         attempts_q   <= attempts_d;
         cycles_q     <= cycles_d;
`endif
      end
   end

   // The block is driven from registers, so it is already stable during
   // the LOAD restart pulse and throughout WAIT.
   assign hash_block  = {nonce_cur_q, payload_q};
   assign hash_next   = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign hash_finish = (state_q == S_DONE);
   assign busy        = busy_st;
   assign done        = (state_q == S_DONE);
   assign found       = found_q;
   assign nonce_out   = nonce_out_q;
   assign hash_out    = hash_out_q;
   assign err_timeout = err_q;
`ifdef HASH_CTRL_STATS_EN
   assign attempts    = attempts_q;
   assign cycles      = cycles_q;
`endif

endmodule

// File: tb/tb_micro_hash_nonce_ctrl.sv
// -----------------------------------------------------------------------------
// tb_micro_hash_nonce_ctrl
//
// Directed bench for micro_hash_nonce_ctrl with a stub hash core whose digest
// is chosen per nonce and whose latency (or silence) is programmable.
// -----------------------------------------------------------------------------
module tb_micro_hash_nonce_ctrl;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         abort;
   logic [95:0]  payload;
   logic [31:0]  nonceStart;
   logic [31:0]  nonceLast;
   logic [7:0]   target;
   logic [127:0] hashBlock;
   logic         hashNext;
   logic         hashFinish;
   logic [23:0]  hashH = '0;
   logic         hashValid = 1'b0;
   logic         busy;
   logic         done;
   logic         found;
   logic [31:0]  nonceOut;
   logic [23:0]  hashOut;
   logic         errTimeout;
`ifdef HASH_CTRL_STATS_EN
   logic [31:0]  attempts;
   logic [31:0]  cycles;
`endif

   int totalChecks = 0;
   int badChecks   = 0;
   int loadCount   = 0;
   int doneCount   = 0;
   int coreCnt     = 0;

   int stubMode    = 0;
   int stubLat     = 70;
   bit stubEnable  = 1'b1;

   micro_hash_nonce_ctrl #(.NONCE_W(32), .TIMEOUT(255)) dut (
      .clk         (clock),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .payload     (payload),
      .nonce_start (nonceStart),
      .nonce_last  (nonceLast),
      .target      (target),
      .hash_block  (hashBlock),
      .hash_next   (hashNext),
      .hash_finish (hashFinish),
      .hash_h      (hashH),
      .hash_valid  (hashValid),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .nonce_out   (nonceOut),
      .hash_out    (hashOut),
`ifdef HASH_CTRL_STATS_EN
      .attempts    (attempts),
      .cycles      (cycles),
`endif
      .err_timeout (errTimeout)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Stub digest: mode 0 is a constant hit for target 0x21, mode 1 only
   // hits at nonce 7 for target 0x10, mode 2 never hits.
   function automatic logic [23:0] stubHash(input logic [31:0] n);
      case (stubMode)
         0:       return 24'h102030;
         1:       return (n == 32'd7) ? 24'h050500 : 24'hFF0000;
         default: return 24'hFFFFFF;
      endcase
   endfunction

   // Stub core: held cleared while hash_next or hash_finish is high, then
   // counts cycles and pulses valid once when the count reaches stubLat.
   always @(posedge clock) begin
      if (hashNext || hashFinish) begin
         coreCnt   <= 0;
         hashValid <= 1'b0;
      end else begin
         coreCnt   <= coreCnt + 1;
         hashValid <= stubEnable && ((coreCnt + 1) == stubLat);
         hashH     <= stubHash(hashBlock[127:96]);
      end
   end

   // Event counters for LOAD cycles (restart pulses while busy) and done
   // pulses; sampled at the active edge so each cycle is counted once.
   always @(posedge clock) begin
      if (busy && hashNext) loadCount <= loadCount + 1;
      if (done) doneCount <= doneCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Present a search request for one cycle; returns on the negedge where
   // start has just been dropped (the DUT is in LOAD there).
   task automatic applyStimulus(input logic [31:0] ns, input logic [31:0] nl, input logic [7:0] tgt);
      @(negedge clock);
      payload    = 96'hA5A5_0000_1111_2222_3333_4444;
      nonceStart = ns;
      nonceLast  = nl;
      target     = tgt;
      start      = 1'b1;
      @(negedge clock);
      start      = 1'b0;
   endtask

   // Waits for the done pulse with a cycle budget; an expired budget shows
   // up as a failed done comparison.
   task automatic waitDone(input string tag, input int maxCycles, output int taken);
      taken = 0;
      do begin
         @(negedge clock);
         taken++;
      end while (!done && (taken < maxCycles));
      checkOutput({tag, " done"}, 128'(done), 128'd1);
   endtask

   int taken;
   int loadSnap;
   int doneSnap;

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      payload    = '0;
      nonceStart = '0;
      nonceLast  = '0;
      target     = '0;
      repeat (3) @(negedge clock);
      checkOutput("rst hash_block", hashBlock, 128'd0);
      checkOutput("rst hash_next", 128'(hashNext), 128'd1);
      checkOutput("rst hash_finish", 128'(hashFinish), 128'd0);
      checkOutput("rst busy", 128'(busy), 128'd0);
      checkOutput("rst done", 128'(done), 128'd0);
      checkOutput("rst found", 128'(found), 128'd0);
      checkOutput("rst nonce_out", 128'(nonceOut), 128'd0);
      checkOutput("rst err", 128'(errTimeout), 128'd0);
      reset = 1'b0;

      // Single hit on the first nonce. Done is seen 73 negedges after the
      // start-drop negedge: 1 LOAD, 71 WAIT (stub valid in the 71st), 1 CHECK.
      stubMode = 0; stubLat = 70; stubEnable = 1'b1;
      loadSnap = loadCount;
      applyStimulus(32'd5, 32'd9, 8'h21);
      checkOutput("t1 block", hashBlock, {32'd5, 96'hA5A5_0000_1111_2222_3333_4444});
      checkOutput("t1 busy", 128'(busy), 128'd1);
      waitDone("t1", 400, taken);
      checkOutput("t1 latency", 128'(taken), 128'd73);
      checkOutput("t1 found", 128'(found), 128'd1);
      checkOutput("t1 nonce_out", 128'(nonceOut), 128'd5);
      checkOutput("t1 hash_out", 128'(hashOut), 128'h102030);
      checkOutput("t1 finish", 128'(hashFinish), 128'd1);
      checkOutput("t1 loads", 128'(loadCount - loadSnap), 128'd1);
`ifdef HASH_CTRL_STATS_EN
      checkOutput("t1 attempts", attempts, 128'd1);
      checkOutput("t1 cycles", cycles, 128'd73);
`endif
      @(negedge clock);
      checkOutput("t1 done pulse", 128'(done), 128'd0);

      // Hit on the third nonce; a start pulse while busy must be ignored.
      stubMode = 1; stubLat = 5;
      loadSnap = loadCount;
      applyStimulus(32'd5, 32'd9, 8'h10);
      repeat (3) @(negedge clock);
      nonceStart = 32'd100;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      waitDone("t2", 200, taken);
      checkOutput("t2 found", 128'(found), 128'd1);
      checkOutput("t2 nonce_out", 128'(nonceOut), 128'd7);
      checkOutput("t2 hash_out", 128'(hashOut), 128'h050500);
      checkOutput("t2 loads", 128'(loadCount - loadSnap), 128'd3);
`ifdef HASH_CTRL_STATS_EN
      checkOutput("t2 attempts", attempts, 128'd3);
`endif

      // Target zero never hits: the whole range 5..7 is walked.
      stubMode = 0;
      loadSnap = loadCount;
      applyStimulus(32'd5, 32'd7, 8'h00);
      waitDone("t3", 200, taken);
      checkOutput("t3 found", 128'(found), 128'd0);
      checkOutput("t3 nonce_out", 128'(nonceOut), 128'd7);
      checkOutput("t3 hash_out", 128'(hashOut), 128'h102030);
      checkOutput("t3 loads", 128'(loadCount - loadSnap), 128'd3);

      // Top of the nonce space: one attempt, no wrap to zero.
      stubMode = 2;
      loadSnap = loadCount;
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h80);
      waitDone("t4", 200, taken);
      checkOutput("t4 found", 128'(found), 128'd0);
      checkOutput("t4 nonce_out", 128'(nonceOut), 128'hFFFF_FFFF);
      repeat (10) @(negedge clock);
      checkOutput("t4 loads", 128'(loadCount - loadSnap), 128'd1);
      checkOutput("t4 idle busy", 128'(busy), 128'd0);

      // Reversed range: exactly one attempt at nonce_start.
      loadSnap = loadCount;
      applyStimulus(32'd9, 32'd5, 8'h00);
      waitDone("t4b", 200, taken);
      checkOutput("t4b nonce_out", 128'(nonceOut), 128'd9);
      checkOutput("t4b loads", 128'(loadCount - loadSnap), 128'd1);

      // Silent core: timeout done 256 cycles after WAIT entry, i.e. 257
      // negedges after the start-drop negedge (one LOAD cycle first).
      stubEnable = 1'b0;
      applyStimulus(32'd20, 32'd30, 8'hFF);
      waitDone("t5", 400, taken);
      checkOutput("t5 latency", 128'(taken), 128'd257);
      checkOutput("t5 err", 128'(errTimeout), 128'd1);
      checkOutput("t5 found", 128'(found), 128'd0);
      checkOutput("t5 nonce_out", 128'(nonceOut), 128'd20);
      repeat (3) @(negedge clock);
      checkOutput("t5 err sticky", 128'(errTimeout), 128'd1);

      // Next start clears the sticky error; abort in the 30th WAIT cycle.
      stubEnable = 1'b1; stubMode = 0; stubLat = 70;
      doneSnap = doneCount;
      applyStimulus(32'd40, 32'd50, 8'h21);
      checkOutput("t6 err cleared", 128'(errTimeout), 128'd0);
      repeat (30) @(negedge clock);
      checkOutput("t6 busy before abort", 128'(busy), 128'd1);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      checkOutput("t6 abort busy", 128'(busy), 128'd0);
      checkOutput("t6 abort next", 128'(hashNext), 128'd1);
      repeat (100) @(negedge clock);
      checkOutput("t6 no done", 128'(doneCount - doneSnap), 128'd0);
      checkOutput("t6 nonce_out kept", 128'(nonceOut), 128'd20);

      // Abort and digest-valid in the same cycle: abort wins.
      stubLat = 5;
      doneSnap = doneCount;
      applyStimulus(32'd1, 32'd3, 8'h21);
      repeat (6) @(negedge clock);
      checkOutput("t6b stub valid", 128'(hashValid), 128'd1);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      checkOutput("t6b abort busy", 128'(busy), 128'd0);
      repeat (20) @(negedge clock);
      checkOutput("t6b no done", 128'(doneCount - doneSnap), 128'd0);
      checkOutput("t6b found kept", 128'(found), 128'd0);

      // Reset in the middle of WAIT returns every output to its reset value.
      stubLat = 70;
      doneSnap = doneCount;
      applyStimulus(32'd5, 32'd9, 8'h21);
      repeat (10) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("t7 hash_block", hashBlock, 128'd0);
      checkOutput("t7 hash_next", 128'(hashNext), 128'd1);
      checkOutput("t7 busy", 128'(busy), 128'd0);
      checkOutput("t7 nonce_out", 128'(nonceOut), 128'd0);
      checkOutput("t7 hash_out", 128'(hashOut), 128'd0);
      checkOutput("t7 found", 128'(found), 128'd0);
      repeat (100) @(negedge clock);
      checkOutput("t7 no done", 128'(doneCount - doneSnap), 128'd0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
